peak_interval_detector: RTL and testbench
=========================================

# peak_interval_detector

Detects systolic peaks in the downsampled, band-limited PPG stream and reports the beat-to-beat interval in samples. It sits directly downstream of the HPF→LPF→DownSampler preprocessing chain and consumes its `ppg_out`/`valid_out` pair. It feeds the BPM computation stage.

## Interface
- `Width`, 10: signed sample width (matches preprocessing output).
- `CNT_W`, 10: interval counter / output width.
- `REFRACT`, 15: samples ignored after each peak event (≥1).
- `MAX_IVL`, 150: interval in samples at which a timeout is declared (< 2^CNT_W).
- `MIN_THR`, 16: threshold floor, signed, Width bits.
- `THR_SHIFT`, 4: threshold decay shift.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: block enable; when low, all state and outputs hold, and pulses deassert.
- `data_in` input Width, signed: downsampled PPG sample.
- `data_valid` input 1: sample strobe; `data_in` is consumed only when `en && data_valid`.
- `peak_flag` output 1: one-cycle pulse per peak event.
- `interval_out` output CNT_W: samples between the last two peak events; held until the next update.
- `interval_valid` output 1: one-cycle pulse when `interval_out` updates.
- `timeout` output 1: one-cycle pulse when no peak occurs for MAX_IVL samples.

## Operation
- A "strobe" is any cycle with `en && data_valid`. All state changes below occur only on strobes. Sample count and interval are in strobes, independent of gaps between them.
- Registers:
  - `state` ∈ {SEARCH, CLIMB, REFR}
  - `thr`: signed, Width bits
  - `maxv`: signed, Width bits
  - `cnt`: CNT_W bits
  - `rcnt`: REFRACT counter
  - `have_prev`: 1 bit
- SEARCH:
  - If `data_in > thr` (signed compare): go to CLIMB and load `maxv <= data_in`.
  - Otherwise: `thr <= max(thr - (thr >>> THR_SHIFT), MIN_THR)`.
- CLIMB:
  - If `data_in >= maxv`: `maxv <= data_in`.
  - Otherwise a **peak event** occurs:
    - Assert `peak_flag`.
    - `thr <= max(maxv >>> 1, MIN_THR)`.
    - `rcnt <= 0`.
    - Go to REFR.
- REFR:
  - Samples are ignored for the comparison.
  - `rcnt` increments each strobe. When `rcnt == REFRACT-1`, go to SEARCH.
- Interval counter, evaluated on each strobe:
  - On a peak event:
    - If `have_prev`, then `interval_out <= cnt + 1` and `interval_valid` pulses.
    - Always `cnt <= 0` and `have_prev <= 1`.
  - Otherwise, `cnt <= cnt + 1`.
- Timeout: on a non-peak strobe where `cnt + 1 == MAX_IVL`:
  - Pulse `timeout`.
  - `cnt <= 0`, `have_prev <= 0`, `thr <= MIN_THR`, `state <= SEARCH`.
  - `interval_out` holds its value.
- Simultaneous peak event and timeout condition on one strobe: the peak event wins and no timeout is raised.
- Arithmetic: all comparisons and shifts are signed. `>>>` is an arithmetic shift. `cnt + 1` is computed at CNT_W+1 bits; it cannot overflow because MAX_IVL < 2^CNT_W.

## Timing
- Reset values:
  - `state = SEARCH`, `thr = MIN_THR`, `maxv = 0`, `cnt = 0`, `rcnt = 0`, `have_prev = 0`.
  - `interval_out = 0`; `peak_flag`, `interval_valid`, `timeout` all 0.
- All outputs are registered. Pulses appear in the cycle after the strobe edge and last exactly one clock. `peak_flag` and `interval_valid` are coincident.
- Latency: a peak event is declared on the first strobe whose sample is below the running maximum, i.e. one sample after the true maximum. The output pulse follows on the next clock edge.
- `rst` asserted mid-operation returns every register to its reset value at the next edge, regardless of `en`. The first peak after reset produces `peak_flag` only.
- `en` low: no register changes; pulse outputs are 0 that cycle.

## Test plan
- **Periodic peaks:** triangle pulses of amplitude 200, period 40 strobes, baseline 0, 4 periods. Required: `peak_flag` ×4, `interval_valid` ×3, each with `interval_out = 40`.
- **Refractory rejection:** a second 300-amplitude spike 8 strobes after a peak event (REFRACT=15). Required: no `peak_flag` for the spike, and the next true peak reports `interval_out = 40`.
- **Timeout:** one peak, then constant 0 for 150 strobes. Required:
  - `timeout` pulses exactly once, on strobe 150 after the peak.
  - `thr = MIN_THR`.
  - The next peak gives `peak_flag` without `interval_valid`.
- **Strobe gaps and enable:** same as the periodic case but with `data_valid` high only every 3rd cycle and `en` low for 10 random cycles. Required: `interval_out = 40` every time.
- **Threshold decay:** a peak of 400, then baseline 0. Required:
  - `thr = 200` after the peak.
  - `thr` decays by `thr >>> 4` per SEARCH strobe down to 16 and never lower.
  - A later 30-amplitude pulse is detected.
- **Mid-run reset:** assert `rst` for 1 cycle between two peaks. Required: all outputs 0 next cycle, and the following peak produces no `interval_valid`.

Source files
------------

// File: rtl/peak_interval_detector.sv
// -----------------------------------------------------------------------------
// peak_interval_detector
//
// Finds systolic peaks in the downsampled, band-limited PPG stream and reports
// the beat-to-beat interval, counted in accepted samples (strobes).
//
// Detection runs as a three-state machine:
//   SEARCH - wait for a sample above the adaptive threshold; the threshold
//            decays geometrically toward a floor while waiting.
//   CLIMB  - track the running maximum; the first sample below it declares a
//            peak, and the threshold is re-armed at half the peak height.
//   REFR   - ignore REFRACT samples so dicrotic notches and ringing can't
//            re-trigger.
// If no peak arrives within MAX_IVL strobes, a timeout pulse is raised, the
// interval history is discarded and detection restarts from the floor.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   en             block enable; when low, all state holds and pulses are 0
//   data_in        signed PPG sample, Width bits
//   data_valid     sample strobe; a sample is consumed when en && data_valid
//   peak_flag      one-cycle pulse per peak event
//   interval_out   strobes between the last two peaks; held between updates
//   interval_valid one-cycle pulse when interval_out updates
//   timeout        one-cycle pulse when no peak arrives within MAX_IVL strobes
// -----------------------------------------------------------------------------
module peak_interval_detector #(
  parameter int Width     = 10,
  parameter int CNT_W     = 10,
  parameter int REFRACT   = 15,
  parameter int MAX_IVL   = 150,
  parameter int MIN_THR   = 16,
  parameter int THR_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [Width-1:0] data_in,
  input  logic                    data_valid,
  output logic                    peak_flag,
  output logic [CNT_W-1:0]        interval_out,
  output logic                    interval_valid,
  output logic                    timeout
);

  typedef enum logic [1:0] {
    SEARCH,
    CLIMB,
    REFR
  } state_t;

  localparam int                      RcntW    = $clog2(REFRACT + 1);
  localparam logic signed [Width-1:0] MinThr   = Width'(MIN_THR);
  localparam logic [RcntW-1:0]        RcntLast = RcntW'(REFRACT - 1);
  localparam logic [CNT_W:0]          MaxIvl   = (CNT_W + 1)'(MAX_IVL);

  state_t                  state_q, state_d;
  logic signed [Width-1:0] thr_q, thr_d;
  logic signed [Width-1:0] maxv_q, maxv_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RcntW-1:0]        rcnt_q, rcnt_d;
  logic                    have_prev_q, have_prev_d;
  logic [CNT_W-1:0]        interval_q, interval_d;
  logic                    peak_q, peak_d;
  logic                    ivalid_q, ivalid_d;
  logic                    timeout_q, timeout_d;

  logic                    strobe;
  logic                    peak_evt;
  logic                    timeout_evt;
  logic [CNT_W:0]          cnt_inc;
  logic signed [Width-1:0] thr_decay;
  logic signed [Width-1:0] thr_decay_cl;
  logic signed [Width-1:0] maxv_half;
  logic signed [Width-1:0] thr_peak;

  assign strobe = en && data_valid;

  // One extra bit so the timeout compare can never alias on wrap.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  // Arithmetic shifts on signed operands keep the threshold math sign-correct.
  assign thr_decay    = thr_q - (thr_q >>> THR_SHIFT);
  assign thr_decay_cl = (thr_decay > MinThr) ? thr_decay : MinThr;
  assign maxv_half    = maxv_q >>> 1;
  assign thr_peak     = (maxv_half > MinThr) ? maxv_half : MinThr;

  // NOTE: every combinational output is given a default before any branch so
  // no path leaves a signal unassigned; otherwise a latch is inferred.
  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    maxv_d      = maxv_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    have_prev_d = have_prev_q;
    interval_d  = interval_q;
    peak_d      = 1'b0;
    ivalid_d    = 1'b0;
    timeout_d   = 1'b0;

    peak_evt    = strobe && (state_q == CLIMB) && (data_in < maxv_q);
    // A peak on the same strobe pre-empts the timeout.
    timeout_evt = strobe && !peak_evt && (cnt_inc == MaxIvl);

    if (strobe) begin
      unique case (state_q)
        SEARCH: begin
          if (data_in > thr_q) begin
            state_d = CLIMB;
            maxv_d  = data_in;
          end else begin
            thr_d = thr_decay_cl;
          end
        end
        CLIMB: begin
          if (!peak_evt) begin
            maxv_d = data_in;
          end else begin
            thr_d   = thr_peak;
            rcnt_d  = '0;
            state_d = REFR;
          end
        end
        REFR: begin
          rcnt_d = rcnt_q + RcntW'(1);
          if (rcnt_q == RcntLast) begin
            state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase

      if (peak_evt) begin
        peak_d = 1'b1;
        // The first peak after reset or timeout has no predecessor to measure.
        if (have_prev_q) begin
          interval_d = cnt_inc[CNT_W-1:0];
          ivalid_d   = 1'b1;
        end
        cnt_d       = '0;
        have_prev_d = 1'b1;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end

      // Timeout restarts detection from scratch; interval_out keeps its value.
      if (timeout_evt) begin
        timeout_d   = 1'b1;
        cnt_d       = '0;
        have_prev_d = 1'b0;
        thr_d       = MinThr;
        state_d     = SEARCH;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      thr_q       <= MinThr;
      maxv_q      <= '0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      have_prev_q <= 1'b0;
      interval_q  <= '0;
      peak_q      <= 1'b0;
      ivalid_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      maxv_q      <= maxv_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      have_prev_q <= have_prev_d;
      interval_q  <= interval_d;
      peak_q      <= peak_d;
      ivalid_q    <= ivalid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign peak_flag      = peak_q;
  assign interval_out   = interval_q;
  assign interval_valid = ivalid_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_peak_interval_detector.sv
// -----------------------------------------------------------------------------
// tb_peak_interval_detector
//
// Directed bench for peak_interval_detector. The stimulus process pushes the
// hand-derived expected pulse (and the interval_out value it must carry) into
// a queue at the moment it drives the strobe that should cause it; a separate
// monitor pops and compares every time the DUT raises any output pulse.
//
// Pulse shape used throughout: rise by `step` per strobe for k = 0..10, fall
// back to 0 by k = 20, zero afterwards. With the first sample below the
// maximum declaring the peak, every pulse fires its peak event on k = 11.
// -----------------------------------------------------------------------------
module tb_peak_interval_detector;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic signed [9:0] data_in;
  logic              data_valid;
  logic              peak_flag;
  logic [9:0]        interval_out;
  logic              interval_valid;
  logic              timeout;

  typedef struct {
    bit pk;
    bit iv;
    bit to;
    int ivl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   last_ivl = 0;

  peak_interval_detector dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .peak_flag      (peak_flag),
    .interval_out   (interval_out),
    .interval_valid (interval_valid),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tri_val(input int k, input int step);
    if (k <= 10) return step * k;
    if (k <= 20) return step * (20 - k);
    return 0;
  endfunction

  // One accepted sample followed by an idle cycle, plus `gap` more idle
  // cycles. On return, outputs reflect this strobe.
  task automatic strobe(input int v, input bit pk, input bit iv, input bit to,
                        input int ivl, input int gap);
    exp_t e;
    @(negedge clk);
    en         = 1'b1;
    data_valid = 1'b1;
    data_in    = 10'(v);
    if (pk || to) begin
      if (iv) last_ivl = ivl;
      e.pk  = pk;
      e.iv  = iv;
      e.to  = to;
      e.ivl = last_ivl;
      sb.push_back(e);
    end
    @(negedge clk);
    data_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // A cycle with a valid-looking, large sample but en low: must be ignored.
  task automatic en_low_cycle();
    @(negedge clk);
    en         = 1'b0;
    data_valid = 1'b1;
    data_in    = 10'sd500;
    @(negedge clk);
    en         = 1'b1;
    data_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    en         = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    en       = 1'b1;
    last_ivl = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_peak_flag"},      32'(peak_flag),      0);
    check({tag, "_interval_valid"}, 32'(interval_valid), 0);
    check({tag, "_timeout"},        32'(timeout),        0);
    check({tag, "_interval_out"},   32'(interval_out),   0);
    check({tag, "_thr"},            32'(dut.thr_q),      16);
  endtask

  // Monitor: every pulse the DUT raises must match the oldest expectation.
  always @(negedge clk) begin
    if (peak_flag || interval_valid || timeout) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, peak_flag, interval_valid, timeout}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", {29'd0, peak_flag, interval_valid, timeout},
              {29'd0, e.pk, e.iv, e.to});
        check("interval_out", 32'(interval_out), 32'(e.ivl));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_thr;
    int n;
    int n_en_low;

    rst        = 1'b1;
    en         = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    check_reset_outputs("reset");

    // Periodic peaks: 4 peaks, 3 intervals of 40.
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 40; k++)
        strobe(tri_val(k, 20), k == 11, (k == 11) && (p > 0), 1'b0, 40, 0);

    // Refractory rejection: a 300 spike 8 strobes after the first peak.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 40; k++)
        strobe((p == 0 && k == 19) ? 300 : tri_val(k, 20),
               k == 11, (k == 11) && (p > 0), 1'b0, 40, 0);

    // Timeout: peak at k=11, zeros until the 150th strobe after it (k=161).
    do_reset();
    for (int k = 0; k < 162; k++)
      strobe(tri_val(k, 20), k == 11, 1'b0, k == 161, 0, 0);
    check("timeout_thr", 32'(dut.thr_q), 16);
    for (int k = 0; k < 21; k++)
      strobe(tri_val(k, 20), k == 11, 1'b0, 1'b0, 0, 0);

    // Strobe gaps (every 3rd cycle) plus 10 enable-low cycles carrying junk.
    do_reset();
    n        = 0;
    n_en_low = 0;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 40; k++) begin
        if ((n % 13 == 5) && (n_en_low < 10)) begin
          en_low_cycle();
          n_en_low++;
        end
        strobe(tri_val(k, 20), k == 11, (k == 11) && (p > 0), 1'b0, 40, 1);
        n++;
      end

    // Threshold decay: 400 peak re-arms at 200, then decays to the 16 floor.
    do_reset();
    for (int k = 0; k < 12; k++)
      strobe(tri_val(k, 40), k == 11, 1'b0, 1'b0, 0, 0);
    check("thr_after_peak", 32'(dut.thr_q), 200);
    for (int k = 12; k < 27; k++)
      strobe(0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("thr_in_refractory", 32'(dut.thr_q), 200);
    exp_thr = 200;
    for (int k = 27; k < 88; k++) begin
      strobe(0, 1'b0, 1'b0, 1'b0, 0, 0);
      exp_thr = exp_thr - (exp_thr >>> 4);
      if (exp_thr < 16) exp_thr = 16;
      check("thr_decay", 32'(dut.thr_q), 32'(exp_thr));
    end
    check("thr_floor", 32'(dut.thr_q), 16);
    strobe(10, 1'b0, 1'b0, 1'b0, 0, 0);   // k=88
    strobe(20, 1'b0, 1'b0, 1'b0, 0, 0);   // k=89, enters CLIMB
    strobe(30, 1'b0, 1'b0, 1'b0, 0, 0);   // k=90
    strobe(20, 1'b1, 1'b1, 1'b0, 80, 0);  // k=91, peak 80 strobes after k=11

    // Mid-run reset between the peaks of periods 1 and 2.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 40; k++)
        strobe(tri_val(k, 20), k == 11, (k == 11) && (p > 0), 1'b0, 40, 0);
    check("pre_reset_interval_out", 32'(interval_out), 40);
    do_reset();
    check_reset_outputs("mid_reset");
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 40; k++)
        strobe(tri_val(k, 20), k == 11, (k == 11) && (p > 0), 1'b0, 40, 0);

    repeat (5) @(negedge clk);
    check("pending_expectations", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
